// File: rtl/matrix_hadamard_mac.sv
// matrix_hadamard_mac: pipelined element-wise multiply(-accumulate) of two NxN matrices, c = a.*b or c += a.*b
// Ports: clk, rst (sync, active-high); start/accumulate/signed_mode/clear controls;
//   a, b operands [N][N][DATA_W]; c result registers [N][N][ACC_W]; busy (run in progress); done (1-cycle, c final).
// Option: define MATRIX_HADAMARD_SAT_EN for saturating accumulation instead of wrap-around.
module matrix_hadamard_mac #(
  parameter int N      = 6,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int LANES  = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                accumulate,
  input  logic                                signed_mode,
  input  logic                                clear,
  input  logic [N-1:0][N-1:0][DATA_W-1:0]     a,
  input  logic [N-1:0][N-1:0][DATA_W-1:0]     b,
  output logic [N-1:0][N-1:0][ACC_W-1:0]      c,
  output logic                                busy,
  output logic                                done
);
  localparam int NE = N * N;
  localparam int G  = (NE + LANES - 1) / LANES;
  localparam int KW = $clog2(G + 1);
  localparam int EW = $clog2(NE + LANES);
  localparam int PW = 2 * DATA_W;
  if (ACC_W < PW) begin : g_bad_acc_w
    $error("ACC_W must be >= 2*DATA_W");
  end
  if (LANES < 1 || LANES > NE) begin : g_bad_lanes
    $error("LANES must be in 1..N*N");
  end
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t                  state;
  logic [KW-1:0]           k;
  logic [NE*DATA_W-1:0]    a_q, b_q;
  logic                    acc_q, sgn_q;
  logic [NE*ACC_W-1:0]     c_q;
  logic [LANES-1:0]        s1_v, v_n;
  logic [EW-1:0]           s1_e [LANES];
  logic [EW-1:0]           e_n  [LANES];
  logic [ACC_W-1:0]        s1_p [LANES];
  logic [ACC_W-1:0]        p_n  [LANES];
  logic signed [PW-1:0]    ps_n [LANES];
  logic [PW-1:0]           pu_n [LANES];
  logic [ACC_W-1:0]        old_n [LANES];
  logic [ACC_W-1:0]        sum_n [LANES];
`ifdef MATRIX_HADAMARD_SAT_EN
  logic [ACC_W:0]          wide_n [LANES];
  logic [LANES-1:0]        ovf_n;
`endif
  assign c = c_q;
  // Stage 1: lane l of group k handles row-major element k*LANES+l; lanes past the end stay disabled.
  always_comb
    for (int l = 0; l < LANES; l++) begin
      v_n[l]  = int'(k) * LANES + l < NE;
      e_n[l]  = v_n[l] ? EW'(int'(k) * LANES + l) : '0;
      ps_n[l] = PW'($signed(a_q[int'(e_n[l]) * DATA_W +: DATA_W])) * PW'($signed(b_q[int'(e_n[l]) * DATA_W +: DATA_W]));
      pu_n[l] = PW'(a_q[int'(e_n[l]) * DATA_W +: DATA_W]) * PW'(b_q[int'(e_n[l]) * DATA_W +: DATA_W]);
      p_n[l]  = sgn_q ? ACC_W'(ps_n[l]) : ACC_W'(pu_n[l]);
    end
  // Stage 2: new value for the element each registered product targets.
  always_comb
    for (int l = 0; l < LANES; l++) begin
      old_n[l] = c_q[int'(s1_e[l]) * ACC_W +: ACC_W];
`ifdef MATRIX_HADAMARD_SAT_EN
      wide_n[l] = {1'b0, old_n[l]} + {1'b0, s1_p[l]};
      ovf_n[l]  = sgn_q ? (old_n[l][ACC_W-1] == s1_p[l][ACC_W-1] && wide_n[l][ACC_W-1] != old_n[l][ACC_W-1])
                        : wide_n[l][ACC_W];
      // Signed overflow can only happen with matching operand signs, so the old sign picks the rail.
      sum_n[l]  = !acc_q ? s1_p[l] :
                  !ovf_n[l] ? wide_n[l][ACC_W-1:0] :
                  sgn_q ? {old_n[l][ACC_W-1], {(ACC_W-1){~old_n[l][ACC_W-1]}}} : '1;
`else
      sum_n[l]  = acc_q ? old_n[l] + s1_p[l] : s1_p[l];
`endif
    end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      k     <= '0;
      s1_v  <= '0;
      c_q   <= '0;
    end else begin
      done <= 1'b0;
      s1_v <= '0;
      for (int l = 0; l < LANES; l++)
        if (s1_v[l]) c_q[int'(s1_e[l]) * ACC_W +: ACC_W] <= sum_n[l];
      case (state)
        IDLE:
          if (clear) c_q <= '0;
          else if (start) begin
            a_q   <= a;
            b_q   <= b;
            acc_q <= accumulate;
            sgn_q <= signed_mode;
            k     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        RUN: begin
          s1_v  <= v_n;
          s1_e  <= e_n;
          s1_p  <= p_n;
          k     <= k + 1'b1;
          state <= k == KW'(G - 1) ? DRAIN : RUN;
        end
        DRAIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_matrix_hadamard_mac.sv
// tb_matrix_hadamard_mac: directed bench with a behavioural matrix model checked every cycle
module tb_matrix_hadamard_mac;
  localparam int N = 6, DW = 16, AW = 32, NE = 36, G = 9;
  localparam longint SMAX = 64'sh7FFFFFFF, SMIN = -64'sh80000000, UMAX = 64'shFFFFFFFF;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, acc = 1'b0, sgn = 1'b0, clr = 1'b0, start_l = 1'b0;
  logic [DW-1:0] av [NE], bv [NE];
  logic [N-1:0][N-1:0][DW-1:0] a, b;
  logic [N-1:0][N-1:0][AW-1:0] c, c36, c1, c5;
  logic busy, done, busy36, done36, busy1, done1, busy5, done5;
  logic [AW-1:0] m_c [NE];
  int tests = 0, fails = 0, cyc = 0, t0 = 0;
  bit act = 0;
  always #5 clk = ~clk;
  always_comb
    for (int e = 0; e < NE; e++) begin
      a[e / N][e % N] = av[e];
      b[e / N][e % N] = bv[e];
    end
  matrix_hadamard_mac u_dut (.clk(clk), .rst(rst), .start(start), .accumulate(acc), .signed_mode(sgn),
    .clear(clr), .a(a), .b(b), .c(c), .busy(busy), .done(done));
  matrix_hadamard_mac #(.LANES(36)) u_l36 (.clk(clk), .rst(rst), .start(start_l), .accumulate(acc),
    .signed_mode(sgn), .clear(1'b0), .a(a), .b(b), .c(c36), .busy(busy36), .done(done36));
  matrix_hadamard_mac #(.LANES(1)) u_l1 (.clk(clk), .rst(rst), .start(start_l), .accumulate(acc),
    .signed_mode(sgn), .clear(1'b0), .a(a), .b(b), .c(c1), .busy(busy1), .done(done1));
  matrix_hadamard_mac #(.LANES(5)) u_l5 (.clk(clk), .rst(rst), .start(start_l), .accumulate(acc),
    .signed_mode(sgn), .clear(1'b0), .a(a), .b(b), .c(c5), .busy(busy5), .done(done5));
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask
  task automatic chk_mat(input string nm, input logic [N-1:0][N-1:0][AW-1:0] cc);
    int bad = -1;
    int k;
    for (int e = 0; e < NE; e++)
      if (bad < 0 && cc[e / N][e % N] !== m_c[e]) bad = e;
    k = bad < 0 ? 0 : bad;
    chk($sformatf("%s[%0d]", nm, k), cc[k / N][k % N], m_c[k]);
  endtask
  function automatic logic [AW-1:0] elem(input logic [AW-1:0] old, input logic [DW-1:0] x, input logic [DW-1:0] y,
                                         input bit ac, input bit sg);
    longint p, s;
    p = sg ? longint'($signed(x)) * longint'($signed(y)) : longint'(x) * longint'(y);
    s = ac ? p + (sg ? longint'($signed(old)) : longint'(old)) : p;
`ifdef MATRIX_HADAMARD_SAT_EN
    if (sg) s = s > SMAX ? SMAX : s < SMIN ? SMIN : s;
    else s = s > UMAX ? UMAX : s;
`endif
    return s[AW-1:0];
  endfunction
  initial forever begin
    bit idle;
    @(posedge clk);
    idle = !act || cyc > t0 + G;
    cyc++;
    if (rst) begin
      act = 0;
      for (int e = 0; e < NE; e++) m_c[e] = '0;
    end else if (idle && clr)
      for (int e = 0; e < NE; e++) m_c[e] = '0;
    else if (idle && start) begin
      act = 1;
      t0 = cyc;
      for (int e = 0; e < NE; e++) m_c[e] = elem(m_c[e], av[e], bv[e], acc, sgn);
    end
  end
  initial forever begin
    bit eb;
    @(negedge clk);
    if (cyc > 0) begin
      eb = act && cyc >= t0 && cyc <= t0 + G;
      chk("busy", busy, eb);
      chk("done", done, act && cyc == t0 + G + 1);
      if (!eb) chk_mat("c", c);
    end
  end
  task automatic fill(input logic [DW-1:0] x, input logic [DW-1:0] y);
    for (int e = 0; e < NE; e++) begin
      av[e] = x;
      bv[e] = y;
    end
  endtask
  task automatic fill_seq();
    for (int e = 0; e < NE; e++) begin
      av[e] = DW'(e + 1);
      bv[e] = DW'(e + 1);
    end
  endtask
  task automatic run(input bit ac, input bit sg, input int want_lat);
    int n = 0;
    acc = ac;
    sgn = sg;
    start = 1'b1;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = 1'b0;
    end while (!done && n < 100);
    chk("latency", n, want_lat);
  endtask
  initial begin
    int n, d36, d1, d5;
    fill(0, 0);
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_c", c[4][1], 0);
    rst = 1'b0;
    @(negedge clk);
    fill_seq();
    run(0, 0, 11);
    chk("t1_c00", c[0][0], 1);
    chk("t1_c23", c[2][3], 256);
    chk("t1_c55", c[5][5], 1296);
    fill(2, 3);
    run(0, 0, 11);
    chk("t2_first", c[1][4], 6);
    run(1, 0, 11);
    chk("t2_acc", c[0][0], 12);
    chk("t2_acc55", c[5][5], 12);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t2_clear", c[3][3], 0);
    fill(7, 7);
    clr = 1'b1;
    start = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    start = 1'b0;
    chk("t2_clrstart_busy", busy, 0);
    chk("t2_clrstart_c", c[2][2], 0);
    repeat (14) @(negedge clk);
    fill(16'hFFFD, 7);
    run(0, 1, 11);
    chk("t3_signed", c[3][2], 32'hFFFFFFEB);
    run(0, 0, 11);
    chk("t3_unsigned", c[3][2], 458731);
    fill(16'h8000, 16'h8000);
    run(0, 1, 11);
    chk("t4_first", c[0][5], 32'h40000000);
    run(1, 1, 11);
    run(1, 1, 11);
`ifdef MATRIX_HADAMARD_SAT_EN
    chk("t4_overflow", c[5][0], 32'h7FFFFFFF);
`else
    chk("t4_overflow", c[5][0], 32'hC0000000);
`endif
    fill_seq();
    acc = 1'b0;
    sgn = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_c", c[5][5], 0);
    repeat (12) @(negedge clk);
    run(0, 0, 11);
    chk("t5_fresh", c[5][5], 1296);
    fill(3, 5);
    acc = 1'b1;
    start = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = n == 2;
      clr = n == 4;
    end while (!done && n < 100);
    start = 1'b0;
    clr = 1'b0;
    chk("t5_busy_start_lat", n, 11);
    chk("t5_busy_start_c", c[5][5], 1311);
    repeat (3) @(negedge clk);
    fill_seq();
    acc = 1'b0;
    start = 1'b1;
    start_l = 1'b1;
    n = 0;
    d36 = 0;
    d1 = 0;
    d5 = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = 1'b0;
      start_l = 1'b0;
      if (done36 && d36 == 0) d36 = n;
      if (done1 && d1 == 0) d1 = n;
      if (done5 && d5 == 0) d5 = n;
    end while ((d36 == 0 || d1 == 0 || d5 == 0) && n < 100);
    chk("t6_lat36", d36, 3);
    chk("t6_lat1", d1, 38);
    chk("t6_lat5", d5, 10);
    chk_mat("t6_c36", c36);
    chk_mat("t6_c1", c1);
    chk_mat("t6_c5", c5);
    chk("t6_c5_last", c5[5][5], 1296);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
